// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared encodings for the RAM arbiter.
//   state_e : arbiter FSM state (RUN = normal sharing, LOCKED = host owns RAM)
//   owner_e : which port a read in flight belongs to
package ram_arbiter_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the CPU datapath
// and a host/loader port. One access is granted per cycle; read data returns
// to the owning port one cycle after the grant.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request (held stable until cpu_gnt)
//   cpu_gnt                      CPU access issued this cycle (combinational)
//   cpu_rdata, cpu_rvalid        CPU read return (rvalid is a 1-cycle pulse)
//   cpu_stall                    CPU must hold state (host lock active)
//   host_req/we/addr/wdata       host request (held stable until host_gnt)
//   host_gnt                     host access issued this cycle (combinational)
//   host_rdata, host_rvalid      host read return
//   host_lock                    host asks for exclusive RAM ownership
//   ram_en/we/addr/wdata/rdata   RAM macro interface (1-cycle read latency)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int HOST_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          host_lock,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int BCW = $clog2(HOST_BURST + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(HOST_BURST);

  state_e          state_q, state_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic            rd_vld_q, rd_vld_d;
  owner_e          rd_own_q, rd_own_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // host_lock is sampled every cycle; the change of ownership lands on the
  // following cycle, so the cycle that raises host_lock is still arbitrated
  // as RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (host_lock)  state_d = ST_LOCKED;
      ST_LOCKED: if (!host_lock) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // ---------------- FSM: outputs (grant + RAM mux) ----------------
  always_comb begin
    cpu_gnt   = 1'b0;
    host_gnt  = 1'b0;
    cpu_stall = (state_q == ST_LOCKED);
    if (rst) begin
      unique case (state_q)
        ST_RUN: begin
          // Host normally wins contention; once it has taken HOST_BURST
          // grants back-to-back against a waiting CPU, the CPU gets one.
          if (host_req && !(cpu_req && burst_cnt_q == BURST_MAX)) host_gnt = 1'b1;
          else if (cpu_req)                                       cpu_gnt  = 1'b1;
        end
        ST_LOCKED: host_gnt = host_req;
        default: ;
      endcase
    end

    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (host_gnt) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  // ---------------- host burst counter ----------------
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == ST_LOCKED || cpu_gnt || !cpu_req) burst_cnt_d = '0;
    else if (host_gnt && burst_cnt_q != BURST_MAX)   burst_cnt_d = burst_cnt_q + 1'b1;
  end

  // ---------------- read return pipeline ----------------
  // The RAM answers one cycle after the grant, so only owner + valid need
  // registering. During the return cycle the owner's rdata is driven straight
  // from ram_rdata and captured so it holds afterwards.
  assign cpu_rvalid  = rd_vld_q && (rd_own_q == OWN_CPU);
  assign host_rvalid = rd_vld_q && (rd_own_q == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? ram_rdata : cpu_rdata_q;
  assign host_rdata  = host_rvalid ? ram_rdata : host_rdata_q;

  always_comb begin
    rd_vld_d     = ram_en && !ram_we;
    rd_own_d     = host_gnt ? OWN_HOST : OWN_CPU;
    cpu_rdata_d  = cpu_rdata;
    host_rdata_d = host_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt_q  <= '0;
      rd_vld_q     <= 1'b0;
      rd_own_q     <= OWN_CPU;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      burst_cnt_q  <= burst_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_own_q     <= rd_own_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule
